// File: rtl/product_accumulator_pkg.sv
// Shared types and default widths for the product accumulator and later MAC stages.
package product_accumulator_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } acc_state_t;

  localparam int unsigned DEFAULT_PRODUCT_WIDTH = 32;
  localparam int unsigned DEFAULT_ACC_WIDTH     = 40;
  localparam int unsigned DEFAULT_COUNT_WIDTH   = 8;
  localparam int unsigned DEFAULT_SATURATE      = 1;

endpackage

// File: rtl/saturating_adder.sv
// Combinational unsigned add with carry-out overflow detect; clamps to all-ones or wraps.
module saturating_adder #(
  parameter int unsigned WIDTH    = 40,
  parameter int unsigned SATURATE = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  logic [WIDTH:0] raw;

  always_comb begin
    raw      = {1'b0, a} + {1'b0, b};
    overflow = raw[WIDTH];
    if (raw[WIDTH] && (SATURATE != 0)) begin
      sum = '1;
    end else begin
      sum = raw[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/product_accumulator_16_bit.sv
// Frame accumulator for the multiplier product stream: sums beats until last,
// then holds sum/count/overflow on a valid/ready output until accepted.
module product_accumulator_16_bit
  import product_accumulator_pkg::*;
#(
  parameter int unsigned PRODUCT_WIDTH = DEFAULT_PRODUCT_WIDTH,
  parameter int unsigned ACC_WIDTH     = DEFAULT_ACC_WIDTH,
  parameter int unsigned COUNT_WIDTH   = DEFAULT_COUNT_WIDTH,
  parameter int unsigned SATURATE      = DEFAULT_SATURATE
) (
  input  logic                     Clock_In,
  input  logic                     Reset_N_In,
  input  logic                     Clear_In,
  input  logic [PRODUCT_WIDTH-1:0] Product_In,
  input  logic                     Product_Valid_In,
  input  logic                     Product_Last_In,
  output logic                     Product_Ready_Out,
  output logic [ACC_WIDTH-1:0]     Sum_Out,
  output logic [COUNT_WIDTH-1:0]   Count_Out,
  output logic                     Overflow_Out,
  output logic                     Sum_Valid_Out,
  input  logic                     Sum_Ready_In
);

  if (ACC_WIDTH < PRODUCT_WIDTH) begin : g_width_check
    $error("ACC_WIDTH must be >= PRODUCT_WIDTH");
  end

  acc_state_t             state;
  logic [ACC_WIDTH-1:0]   acc;
  logic [COUNT_WIDTH-1:0] count;
  logic                   ovf;

  logic [ACC_WIDTH-1:0]   product_ext;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic                   add_ovf;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   ovf_next;
  logic                   accept;

  always_comb begin
    product_ext                     = '0;
    product_ext[PRODUCT_WIDTH-1:0]  = Product_In;
  end

  saturating_adder #(
    .WIDTH    (ACC_WIDTH),
    .SATURATE (SATURATE)
  ) u_adder (
    .a        (acc),
    .b        (product_ext),
    .sum      (acc_next),
    .overflow (add_ovf)
  );

  assign count_next        = (count == '1) ? count : count + COUNT_WIDTH'(1);
  assign ovf_next          = ovf | add_ovf;
  assign Product_Ready_Out = (state == ACCUM);
  assign accept            = Product_Valid_In && Product_Ready_Out;

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state         <= ACCUM;
      acc           <= '0;
      count         <= '0;
      ovf           <= 1'b0;
      Sum_Out       <= '0;
      Count_Out     <= '0;
      Overflow_Out  <= 1'b0;
      Sum_Valid_Out <= 1'b0;
    end else if (Clear_In) begin
      state         <= ACCUM;
      acc           <= '0;
      count         <= '0;
      ovf           <= 1'b0;
      Sum_Out       <= '0;
      Count_Out     <= '0;
      Overflow_Out  <= 1'b0;
      Sum_Valid_Out <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (Product_Last_In) begin
              // Last beat bypasses the running registers straight into the result.
              Sum_Out       <= acc_next;
              Count_Out     <= count_next;
              Overflow_Out  <= ovf_next;
              Sum_Valid_Out <= 1'b1;
              acc           <= '0;
              count         <= '0;
              ovf           <= 1'b0;
              state         <= OUTPUT;
            end else begin
              acc   <= acc_next;
              count <= count_next;
              ovf   <= ovf_next;
            end
          end
        end
        OUTPUT: begin
          if (Sum_Ready_In) begin
            Sum_Valid_Out <= 1'b0;
            state         <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator_16_bit.sv
// Bench for product_accumulator_16_bit: default, 33-bit saturating and 33-bit wrapping instances.
module tb_product_accumulator_16_bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] prod = '0;
  logic        pvalid = 1'b0;
  logic        plast = 1'b0;
  logic        sum_ready = 1'b1;

  logic        rdy_a, rdy_s, rdy_w;
  logic        val_a, val_s, val_w;
  logic        ovf_a, ovf_s, ovf_w;
  logic [39:0] sum_a;
  logic [32:0] sum_s, sum_w;
  logic [7:0]  cnt_a, cnt_s, cnt_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  product_accumulator_16_bit u_dut (
    .Clock_In(clk), .Reset_N_In(rst_n), .Clear_In(clear), .Product_In(prod),
    .Product_Valid_In(pvalid), .Product_Last_In(plast), .Product_Ready_Out(rdy_a),
    .Sum_Out(sum_a), .Count_Out(cnt_a), .Overflow_Out(ovf_a),
    .Sum_Valid_Out(val_a), .Sum_Ready_In(sum_ready));

  product_accumulator_16_bit #(.ACC_WIDTH(33), .SATURATE(1)) u_sat33 (
    .Clock_In(clk), .Reset_N_In(rst_n), .Clear_In(clear), .Product_In(prod),
    .Product_Valid_In(pvalid), .Product_Last_In(plast), .Product_Ready_Out(rdy_s),
    .Sum_Out(sum_s), .Count_Out(cnt_s), .Overflow_Out(ovf_s),
    .Sum_Valid_Out(val_s), .Sum_Ready_In(sum_ready));

  product_accumulator_16_bit #(.ACC_WIDTH(33), .SATURATE(0)) u_wrap33 (
    .Clock_In(clk), .Reset_N_In(rst_n), .Clear_In(clear), .Product_In(prod),
    .Product_Valid_In(pvalid), .Product_Last_In(plast), .Product_Ready_Out(rdy_w),
    .Sum_Out(sum_w), .Count_Out(cnt_w), .Overflow_Out(ovf_w),
    .Sum_Valid_Out(val_w), .Sum_Ready_In(sum_ready));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: exact frame total, with the width rule applied only at frame end.
  int unsigned  widths [3] = '{40, 33, 33};
  bit           sat    [3] = '{1'b1, 1'b1, 1'b0};
  logic [63:0]  m_total = '0;
  int           m_beats = 0;
  logic         m_valid = 1'b0;
  logic [63:0]  m_sum [3] = '{64'd0, 64'd0, 64'd0};
  logic [7:0]   m_count = '0;
  logic         m_ovf [3] = '{1'b0, 1'b0, 1'b0};

  function automatic logic [63:0] max_of(int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [63:0] t;
    int          b;
    if (!rst_n || clear) begin
      m_total <= '0;
      m_beats <= 0;
      m_valid <= 1'b0;
      m_count <= '0;
      for (int i = 0; i < 3; i++) begin
        m_sum[i] <= '0;
        m_ovf[i] <= 1'b0;
      end
    end else if (m_valid) begin
      if (sum_ready) m_valid <= 1'b0;
    end else if (pvalid) begin
      t = m_total + 64'(prod);
      b = m_beats + 1;
      if (plast) begin
        for (int i = 0; i < 3; i++) begin
          if (t > max_of(widths[i])) begin
            m_sum[i] <= sat[i] ? max_of(widths[i]) : (t & max_of(widths[i]));
            m_ovf[i] <= 1'b1;
          end else begin
            m_sum[i] <= t;
            m_ovf[i] <= 1'b0;
          end
        end
        m_count <= (b > 255) ? 8'd255 : 8'(b);
        m_valid <= 1'b1;
        m_total <= '0;
        m_beats <= 0;
      end else begin
        m_total <= t;
        m_beats <= b;
      end
    end
  end

  always @(negedge clk) begin
    check("ready[0]", 64'(rdy_a), 64'(!m_valid));
    check("ready[1]", 64'(rdy_s), 64'(!m_valid));
    check("ready[2]", 64'(rdy_w), 64'(!m_valid));
    check("valid[0]", 64'(val_a), 64'(m_valid));
    check("valid[1]", 64'(val_s), 64'(m_valid));
    check("valid[2]", 64'(val_w), 64'(m_valid));
    check("sum[0]", 64'(sum_a), m_sum[0]);
    check("sum[1]", 64'(sum_s), m_sum[1]);
    check("sum[2]", 64'(sum_w), m_sum[2]);
    check("count[0]", 64'(cnt_a), 64'(m_count));
    check("count[1]", 64'(cnt_s), 64'(m_count));
    check("count[2]", 64'(cnt_w), 64'(m_count));
    check("ovf[0]", 64'(ovf_a), 64'(m_ovf[0]));
    check("ovf[1]", 64'(ovf_s), 64'(m_ovf[1]));
    check("ovf[2]", 64'(ovf_w), 64'(m_ovf[2]));
  end

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic send(input logic [31:0] p, input logic l);
    int n = 0;
    pvalid = 1'b1;
    prod   = p;
    plast  = l;
    while (!rdy_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("send_timeout", 64'd1, 64'd0);
    @(negedge clk);
    pvalid = 1'b0;
    plast  = 1'b0;
  endtask

  task automatic zero_outputs(input string tag);
    check({tag, "_valid"}, 64'(val_a), 64'd0);
    check({tag, "_sum"},   64'(sum_a), 64'd0);
    check({tag, "_count"}, 64'(cnt_a), 64'd0);
    check({tag, "_ovf"},   64'(ovf_a), 64'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    zero_outputs("reset");
    check("reset_ready", 64'(rdy_a), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame
    send(32'd6, 1'b0);
    send(32'd20, 1'b0);
    send(32'd100, 1'b1);
    check("basic_valid", 64'(val_a), 64'd1);
    check("basic_sum",   64'(sum_a), 64'd126);
    check("basic_count", 64'(cnt_a), 64'd3);
    check("basic_ovf",   64'(ovf_a), 64'd0);
    @(negedge clk);
    check("basic_drop",  64'(val_a), 64'd0);
    check("basic_ready", 64'(rdy_a), 64'd1);

    // Single-beat frame
    send(32'hFFFE_0001, 1'b1);
    check("single_sum",   64'(sum_a), 64'hFFFE_0001);
    check("single_count", 64'(cnt_a), 64'd1);
    @(negedge clk);

    // Backpressure
    sum_ready = 1'b0;
    send(32'd40, 1'b0);
    send(32'd2, 1'b1);
    pvalid = 1'b1;
    prod   = 32'd7;
    plast  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", 64'(rdy_a), 64'd0);
      check("bp_sum",   64'(sum_a), 64'd42);
      @(negedge clk);
    end
    sum_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(val_a), 64'd0);
    check("bp_release_ready", 64'(rdy_a), 64'd1);
    @(negedge clk);
    pvalid = 1'b0;
    plast  = 1'b0;
    check("bp_next_sum",   64'(sum_a), 64'd7);
    check("bp_next_count", 64'(cnt_a), 64'd1);
    @(negedge clk);

    // Overflow on 33-bit instances
    send(32'hFFFE_0001, 1'b0);
    send(32'hFFFE_0001, 1'b0);
    send(32'hFFFE_0001, 1'b1);
    check("ovf_sat_sum",  64'(sum_s), 64'h1_FFFF_FFFF);
    check("ovf_sat_flag", 64'(ovf_s), 64'd1);
    check("ovf_wrap_sum", 64'(sum_w), 64'h0_FFFA_0003);
    check("ovf_wrap_flag", 64'(ovf_w), 64'd1);
    check("ovf_wide_sum", 64'(sum_a), 64'h2_FFFA_0003);
    check("ovf_wide_flag", 64'(ovf_a), 64'd0);
    @(negedge clk);
    send(32'd9, 1'b1);
    check("clean_sat_flag",  64'(ovf_s), 64'd0);
    check("clean_wrap_flag", 64'(ovf_w), 64'd0);
    check("clean_wrap_sum",  64'(sum_w), 64'd9);
    @(negedge clk);

    // Clear mid-frame, with a discarded last beat in the clear cycle
    send(32'd50, 1'b0);
    send(32'd50, 1'b0);
    clear  = 1'b1;
    pvalid = 1'b1;
    prod   = 32'd99;
    plast  = 1'b1;
    @(negedge clk);
    clear  = 1'b0;
    pvalid = 1'b0;
    plast  = 1'b0;
    zero_outputs("clear");
    send(32'd3, 1'b1);
    check("clear_sum",   64'(sum_a), 64'd3);
    check("clear_count", 64'(cnt_a), 64'd1);
    @(negedge clk);

    // Beat counter saturation
    for (int i = 0; i < 259; i++) send(32'd1, 1'b0);
    send(32'd1, 1'b1);
    check("cnt_sat_count", 64'(cnt_a), 64'd255);
    check("cnt_sat_sum",   64'(sum_a), 64'd260);
    @(negedge clk);

    // Async reset mid-frame
    send(32'd11, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    zero_outputs("rst_frame");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'd5, 1'b1);
    check("rst_frame_sum",   64'(sum_a), 64'd5);
    check("rst_frame_count", 64'(cnt_a), 64'd1);
    @(negedge clk);

    // Async reset while holding a result
    sum_ready = 1'b0;
    send(32'd12, 1'b1);
    check("rst_out_held", 64'(val_a), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    zero_outputs("rst_out");
    check("rst_out_ready", 64'(rdy_a), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    sum_ready = 1'b1;
    @(negedge clk);
    send(32'd5, 1'b1);
    check("rst_out_sum",   64'(sum_a), 64'd5);
    check("rst_out_count", 64'(cnt_a), 64'd1);
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
